// File: rtl/decode_stage.sv
// RV32I(+M) decode stage: combinational decode into a single ID/EX register,
// valid/ready handshake, load-use bubble insertion, flush and a stall counter.

package decode_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,  ALU_SUB  = 4'd1,  ALU_XOR  = 4'd2,  ALU_OR   = 4'd3,
    ALU_AND  = 4'd4,  ALU_SLL  = 4'd5,  ALU_SRL  = 4'd6,  ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,  ALU_SLTU = 4'd9,  ALU_EQ   = 4'd10, ALU_NE   = 4'd11,
    ALU_LT   = 4'd12, ALU_GE   = 4'd13, ALU_LTU  = 4'd14, ALU_GEU  = 4'd15
  } alu_opcode_e;

  typedef enum logic [1:0] {OP_A_REG = 2'd0, OP_A_PC = 2'd1} op_a_sel_e;
  typedef enum logic [1:0] {OP_B_REG = 2'd0, OP_B_IMM = 2'd1} op_b_sel_e;
  typedef enum logic [1:0] {RF_WP_ALU = 2'd0, RF_WP_LSU = 2'd1, RF_WP_PC4 = 2'd2, RF_WP_MD = 2'd3} rf_wp_sel_e;
  typedef enum logic [1:0] {ALU_RES_ARITH = 2'd0, ALU_RES_SHIFT = 2'd1, ALU_RES_CMP = 2'd2} alu_res_sel_e;
  typedef enum logic [1:0] {CTRL_NONE = 2'd0, CTRL_JAL = 2'd1, CTRL_JALR = 2'd2, CTRL_BRANCH = 2'd3} ctrl_transfer_e;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;

  typedef struct packed {
    alu_opcode_e    alu_op;
    op_a_sel_e      op_a_sel;
    op_b_sel_e      op_b_sel;
    logic           imm_valid;
    logic [4:0]     rs1;
    logic [4:0]     rs2;
    logic [4:0]     rd;
    logic           rs1_used;
    logic           rs2_used;
    logic           rd_used;
    rf_wp_sel_e     rf_wp_sel;
    alu_res_sel_e   alu_res_sel;
    ctrl_transfer_e ctrl;
    logic           data_req;
    logic           data_we;
    logic           data_sign_ext;
    logic [1:0]     data_type;
    logic           mul_div_req;
    logic [2:0]     mul_div_op;
    logic           invalid;
  } dec_t;

  localparam dec_t DEC_RESET = '{
    alu_op: ALU_ADD, op_a_sel: OP_A_REG, op_b_sel: OP_B_REG, imm_valid: 1'b0,
    rs1: 5'd0, rs2: 5'd0, rd: 5'd0, rs1_used: 1'b0, rs2_used: 1'b0, rd_used: 1'b0,
    rf_wp_sel: RF_WP_ALU, alu_res_sel: ALU_RES_ARITH, ctrl: CTRL_NONE,
    data_req: 1'b0, data_we: 1'b0, data_sign_ext: 1'b0, data_type: 2'b10,
    mul_div_req: 1'b0, mul_div_op: 3'd0, invalid: 1'b0
  };

endpackage

module decode_stage import decode_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter bit RV32M_EN   = 1'b0,
  parameter bit HAZARD_EN  = 1'b1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           instr_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  instr_valid_i,
  output logic                  id_ready_o,
  input  logic                  flush_i,
  input  logic                  ex_ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] pc_o,
  output alu_opcode_e           alu_operator_o,
  output op_a_sel_e             alu_op_a_mux_sel_o,
  output op_b_sel_e             alu_op_b_mux_sel_o,
  output logic [DATA_WIDTH-1:0] imm_o,
  output logic                  imm_valid_o,
  output logic [4:0]            rs1_o,
  output logic [4:0]            rs2_o,
  output logic [4:0]            rd_o,
  output logic                  rs1_used_o,
  output logic                  rs2_used_o,
  output logic                  rd_used_o,
  output rf_wp_sel_e            rf_wp_mux_sel_o,
  output alu_res_sel_e          alu_result_mux_sel_o,
  output ctrl_transfer_e        ctrl_transfer_instr_o,
  output logic                  data_req_o,
  output logic                  data_we_o,
  output logic                  data_sign_ext_o,
  output logic [1:0]            data_type_o,
  output logic                  mul_div_req_o,
  output logic [2:0]            mul_div_op_o,
  output logic                  instr_invalid_o,
  output logic                  hazard_stall_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm32;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];
  assign funct7 = instr_i[31:25];
  assign imm_i  = {{20{instr_i[31]}}, instr_i[31:20]};
  assign imm_s  = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
  assign imm_b  = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
  assign imm_u  = {instr_i[31:12], 12'h000};
  assign imm_j  = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};

  dec_t                  dec, dec_q;
  logic [DATA_WIDTH-1:0] imm_d, imm_q, pc_q;
  logic                  valid_q, accept;
  logic [CNT_WIDTH-1:0]  stall_cnt_q;

  // NOTE: every field gets its default before the case so no path can infer a latch.
  always_comb begin
    dec     = DEC_RESET;
    imm32   = '0;
    dec.rs1 = instr_i[19:15];
    dec.rs2 = instr_i[24:20];
    dec.rd  = instr_i[11:7];
    unique case (opcode)
      OPC_LUI: begin
        dec.rs1 = 5'd0; dec.op_b_sel = OP_B_IMM; dec.imm_valid = 1'b1; dec.rd_used = 1'b1; imm32 = imm_u;
      end
      OPC_AUIPC: begin
        dec.op_a_sel = OP_A_PC; dec.op_b_sel = OP_B_IMM; dec.imm_valid = 1'b1; dec.rd_used = 1'b1; imm32 = imm_u;
      end
      OPC_JAL: begin
        dec.op_a_sel = OP_A_PC; dec.op_b_sel = OP_B_IMM; dec.imm_valid = 1'b1; dec.rd_used = 1'b1;
        dec.ctrl = CTRL_JAL; dec.rf_wp_sel = RF_WP_PC4; imm32 = imm_j;
      end
      OPC_JALR: begin
        dec.op_b_sel = OP_B_IMM; dec.imm_valid = 1'b1; dec.rs1_used = 1'b1; dec.rd_used = 1'b1;
        dec.ctrl = CTRL_JALR; dec.rf_wp_sel = RF_WP_PC4; imm32 = imm_i; dec.invalid = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        dec.imm_valid = 1'b1; dec.rs1_used = 1'b1; dec.rs2_used = 1'b1; dec.ctrl = CTRL_BRANCH; imm32 = imm_b;
        unique case (funct3)
          3'b000:  dec.alu_op = ALU_EQ;
          3'b001:  dec.alu_op = ALU_NE;
          3'b100:  dec.alu_op = ALU_LT;
          3'b101:  dec.alu_op = ALU_GE;
          3'b110:  dec.alu_op = ALU_LTU;
          3'b111:  dec.alu_op = ALU_GEU;
          default: dec.invalid = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.op_b_sel = OP_B_IMM; dec.imm_valid = 1'b1; dec.rs1_used = 1'b1; dec.rd_used = 1'b1;
        dec.data_req = 1'b1; dec.data_sign_ext = ~instr_i[14]; dec.data_type = funct3[1:0];
        dec.rf_wp_sel = RF_WP_LSU; imm32 = imm_i;
        dec.invalid = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        dec.op_b_sel = OP_B_IMM; dec.imm_valid = 1'b1; dec.rs1_used = 1'b1; dec.rs2_used = 1'b1;
        dec.data_req = 1'b1; dec.data_we = 1'b1; dec.data_type = funct3[1:0]; imm32 = imm_s;
        dec.invalid = (funct3 > 3'b010);
      end
      OPC_OP_IMM: begin
        dec.op_b_sel = OP_B_IMM; dec.imm_valid = 1'b1; dec.rs1_used = 1'b1; dec.rd_used = 1'b1; imm32 = imm_i;
        unique case (funct3)
          3'b000: dec.alu_op = ALU_ADD;
          3'b010: begin dec.alu_op = ALU_SLT;  dec.alu_res_sel = ALU_RES_CMP; end
          3'b011: begin dec.alu_op = ALU_SLTU; dec.alu_res_sel = ALU_RES_CMP; end
          3'b100: dec.alu_op = ALU_XOR;
          3'b110: dec.alu_op = ALU_OR;
          3'b111: dec.alu_op = ALU_AND;
          3'b001: begin
            dec.alu_op = ALU_SLL; dec.alu_res_sel = ALU_RES_SHIFT; dec.invalid = (funct7 != 7'b0000000);
          end
          3'b101: begin
            dec.alu_op = instr_i[30] ? ALU_SRA : ALU_SRL; dec.alu_res_sel = ALU_RES_SHIFT;
            dec.invalid = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
          end
          default: dec.invalid = 1'b1;
        endcase
      end
      OPC_OP: begin
        dec.rs1_used = 1'b1; dec.rs2_used = 1'b1; dec.rd_used = 1'b1;
        unique case (funct7)
          7'b0000000: begin
            unique case (funct3)
              3'b000:  dec.alu_op = ALU_ADD;
              3'b001:  begin dec.alu_op = ALU_SLL;  dec.alu_res_sel = ALU_RES_SHIFT; end
              3'b010:  begin dec.alu_op = ALU_SLT;  dec.alu_res_sel = ALU_RES_CMP;   end
              3'b011:  begin dec.alu_op = ALU_SLTU; dec.alu_res_sel = ALU_RES_CMP;   end
              3'b100:  dec.alu_op = ALU_XOR;
              3'b101:  begin dec.alu_op = ALU_SRL;  dec.alu_res_sel = ALU_RES_SHIFT; end
              3'b110:  dec.alu_op = ALU_OR;
              3'b111:  dec.alu_op = ALU_AND;
              default: dec.invalid = 1'b1;
            endcase
          end
          7'b0100000: begin
            unique case (funct3)
              3'b000:  dec.alu_op = ALU_SUB;
              3'b101:  begin dec.alu_op = ALU_SRA; dec.alu_res_sel = ALU_RES_SHIFT; end
              default: dec.invalid = 1'b1;
            endcase
          end
          7'b0000001: begin
            if (RV32M_EN) begin
              dec.mul_div_req = 1'b1; dec.mul_div_op = funct3; dec.rf_wp_sel = RF_WP_MD;
            end else begin
              dec.invalid = 1'b1;
            end
          end
          default: dec.invalid = 1'b1;
        endcase
      end
      OPC_MISC_MEM: ;  // FENCE is a no-op on this in-order pipeline
      // SYSTEM and unknown opcodes take the illegal path so the trap logic downstream handles them.
      default: dec.invalid = 1'b1;
    endcase
    // An illegal instruction must not touch memory, registers or the multiplier.
    if (dec.invalid) begin
      dec.rd_used     = 1'b0;
      dec.data_req    = 1'b0;
      dec.data_we     = 1'b0;
      dec.mul_div_req = 1'b0;
      dec.ctrl        = CTRL_NONE;
    end
  end

  assign imm_d = DATA_WIDTH'($signed(imm32));

  logic load_in_ex, rs_match;
  assign load_in_ex     = valid_q & dec_q.data_req & ~dec_q.data_we & (dec_q.rd != 5'd0);
  assign rs_match       = (dec.rs1_used & (dec.rs1 == dec_q.rd)) | (dec.rs2_used & (dec.rs2 == dec_q.rd));
  assign hazard_stall_o = HAZARD_EN & instr_valid_i & load_in_ex & rs_match;
  assign id_ready_o     = (~valid_q | ex_ready_i) & ~hazard_stall_o & ~flush_i;
  assign accept         = instr_valid_i & id_ready_o;

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      dec_q   <= DEC_RESET;
      imm_q   <= '0;
      pc_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (accept) begin
      valid_q <= 1'b1;
      dec_q   <= dec;
      imm_q   <= imm_d;
      pc_q    <= pc_i;
    end else if (ex_ready_i) begin
      valid_q <= 1'b0;  // drained, or a load leaving with a bubble behind it
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (hazard_stall_o && !flush_i && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign valid_o               = valid_q;
  assign pc_o                  = pc_q;
  assign imm_o                 = imm_q;
  assign alu_operator_o        = dec_q.alu_op;
  assign alu_op_a_mux_sel_o    = dec_q.op_a_sel;
  assign alu_op_b_mux_sel_o    = dec_q.op_b_sel;
  assign imm_valid_o           = dec_q.imm_valid;
  assign rs1_o                 = dec_q.rs1;
  assign rs2_o                 = dec_q.rs2;
  assign rd_o                  = dec_q.rd;
  assign rs1_used_o            = dec_q.rs1_used;
  assign rs2_used_o            = dec_q.rs2_used;
  assign rd_used_o             = dec_q.rd_used;
  assign rf_wp_mux_sel_o       = dec_q.rf_wp_sel;
  assign alu_result_mux_sel_o  = dec_q.alu_res_sel;
  assign ctrl_transfer_instr_o = dec_q.ctrl;
  assign data_req_o            = dec_q.data_req;
  assign data_we_o             = dec_q.data_we;
  assign data_sign_ext_o       = dec_q.data_sign_ext;
  assign data_type_o           = dec_q.data_type;
  assign mul_div_req_o         = dec_q.mul_div_req;
  assign mul_div_op_o          = dec_q.mul_div_op;
  assign instr_invalid_o       = dec_q.invalid;
  assign stall_cnt_o           = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: dut_a has RV32M and hazards on with a 2-bit
// counter, dut_b has both off; both see the same stimulus.

module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr, pc;
  logic        instr_valid, flush, ex_ready;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  logic a_id_ready, a_valid, a_imm_valid, a_rs1_used, a_rs2_used, a_rd_used;
  logic a_req, a_we, a_sext, a_md_req, a_inv, a_hazard;
  logic [31:0] a_pc, a_imm;
  logic [4:0]  a_rs1, a_rs2, a_rd;
  logic [1:0]  a_dtype;
  logic [2:0]  a_md_op;
  logic [1:0]  a_cnt;
  alu_opcode_e a_alu;
  op_a_sel_e a_op_a;
  op_b_sel_e a_op_b;
  rf_wp_sel_e a_rf_wp;
  alu_res_sel_e a_res;
  ctrl_transfer_e a_ctrl;

  logic b_id_ready, b_valid, b_imm_valid, b_rs1_used, b_rs2_used, b_rd_used;
  logic b_req, b_we, b_sext, b_md_req, b_inv, b_hazard;
  logic [31:0] b_pc, b_imm;
  logic [4:0]  b_rs1, b_rs2, b_rd;
  logic [1:0]  b_dtype;
  logic [2:0]  b_md_op;
  logic [15:0] b_cnt;
  alu_opcode_e b_alu;
  op_a_sel_e b_op_a;
  op_b_sel_e b_op_b;
  rf_wp_sel_e b_rf_wp;
  alu_res_sel_e b_res;
  ctrl_transfer_e b_ctrl;

  decode_stage #(.DATA_WIDTH(32), .RV32M_EN(1'b1), .HAZARD_EN(1'b1), .CNT_WIDTH(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .instr_i(instr), .pc_i(pc), .instr_valid_i(instr_valid),
    .id_ready_o(a_id_ready), .flush_i(flush), .ex_ready_i(ex_ready), .valid_o(a_valid),
    .pc_o(a_pc), .alu_operator_o(a_alu), .alu_op_a_mux_sel_o(a_op_a), .alu_op_b_mux_sel_o(a_op_b),
    .imm_o(a_imm), .imm_valid_o(a_imm_valid), .rs1_o(a_rs1), .rs2_o(a_rs2), .rd_o(a_rd),
    .rs1_used_o(a_rs1_used), .rs2_used_o(a_rs2_used), .rd_used_o(a_rd_used),
    .rf_wp_mux_sel_o(a_rf_wp), .alu_result_mux_sel_o(a_res), .ctrl_transfer_instr_o(a_ctrl),
    .data_req_o(a_req), .data_we_o(a_we), .data_sign_ext_o(a_sext), .data_type_o(a_dtype),
    .mul_div_req_o(a_md_req), .mul_div_op_o(a_md_op), .instr_invalid_o(a_inv),
    .hazard_stall_o(a_hazard), .stall_cnt_o(a_cnt)
  );

  decode_stage #(.DATA_WIDTH(32), .RV32M_EN(1'b0), .HAZARD_EN(1'b0), .CNT_WIDTH(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .instr_i(instr), .pc_i(pc), .instr_valid_i(instr_valid),
    .id_ready_o(b_id_ready), .flush_i(flush), .ex_ready_i(ex_ready), .valid_o(b_valid),
    .pc_o(b_pc), .alu_operator_o(b_alu), .alu_op_a_mux_sel_o(b_op_a), .alu_op_b_mux_sel_o(b_op_b),
    .imm_o(b_imm), .imm_valid_o(b_imm_valid), .rs1_o(b_rs1), .rs2_o(b_rs2), .rd_o(b_rd),
    .rs1_used_o(b_rs1_used), .rs2_used_o(b_rs2_used), .rd_used_o(b_rd_used),
    .rf_wp_mux_sel_o(b_rf_wp), .alu_result_mux_sel_o(b_res), .ctrl_transfer_instr_o(b_ctrl),
    .data_req_o(b_req), .data_we_o(b_we), .data_sign_ext_o(b_sext), .data_type_o(b_dtype),
    .mul_div_req_o(b_md_req), .mul_div_op_o(b_md_op), .instr_invalid_o(b_inv),
    .hazard_stall_o(b_hazard), .stall_cnt_o(b_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic do_reset();
    instr_valid = 1'b0;
    flush       = 1'b0;
    ex_ready    = 1'b1;
    rst_n       = 1'b0;
    tick();
    rst_n       = 1'b1;
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    alu_opcode_e alu;
    logic        inv;
    logic        chk;
    logic        rd_used;
    logic        req;
    logic        we;
    logic        sext;
    logic [1:0]  dtype;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{32'hFFF34283, 32'hFFFFFFFF, ALU_ADD, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00}; // lbu x5,-1(x6)
    vecs[1] = '{32'h00031283, 32'h00000000, ALU_ADD, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b01}; // lh x5,0(x6)
    vecs[2] = '{32'h00033283, 32'h00000000, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00}; // load funct3=011
    vecs[3] = '{32'h0020A423, 32'h00000008, ALU_ADD, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b10}; // sw x2,8(x1)
    vecs[4] = '{32'h0020B423, 32'h00000008, ALU_ADD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00}; // store funct3=011
    vecs[5] = '{32'h123453B7, 32'h12345000, ALU_ADD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10}; // lui x7,0x12345
    vecs[6] = '{32'hFFC280E7, 32'hFFFFFFFC, ALU_ADD, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10}; // jalr x1,-4(x5)
    vecs[7] = '{32'h0000007F, 32'h00000000, ALU_ADD, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10}; // unknown opcode
    vecs[8] = '{32'h402081B3, 32'h00000000, ALU_SUB, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10}; // sub x3,x1,x2
    vecs[9] = '{32'h00208463, 32'h00000008, ALU_EQ,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10}; // beq x1,x2,+8

    instr = '0; pc = '0; instr_valid = 1'b0; flush = 1'b0; ex_ready = 1'b1; rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;

    at_neg();
    check("rst_valid", 32'(a_valid), 0);
    check("rst_alu", 32'(a_alu), 32'(ALU_ADD));
    check("rst_dtype", 32'(a_dtype), 2);
    check("rst_cnt", 32'(a_cnt), 0);
    tick();

    // single accept: addi x1,x0,5
    instr = 32'h00500093; pc = 32'h100; instr_valid = 1'b1; ex_ready = 1'b1;
    at_neg();
    check("acc_ready", 32'(a_id_ready), 1);
    tick();
    instr_valid = 1'b0;
    at_neg();
    check("acc_valid", 32'(a_valid), 1);
    check("acc_alu", 32'(a_alu), 32'(ALU_ADD));
    check("acc_imm", a_imm, 5);
    check("acc_rd", 32'(a_rd), 1);
    check("acc_rs1_used", 32'(a_rs1_used), 1);
    check("acc_op_b", 32'(a_op_b), 32'(OP_B_IMM));
    check("acc_pc", a_pc, 32'h100);
    check("acc_b_imm", b_imm, 5);
    tick();
    at_neg();
    check("acc_drain", 32'(a_valid), 0);
    tick();

    // load-use: lw x2,0(x1) then add x3,x2,x1
    do_reset();
    instr = 32'h0000A103; instr_valid = 1'b1;
    tick();
    instr = 32'h001101B3;
    at_neg();
    check("lu_hazard", 32'(a_hazard), 1);
    check("lu_ready", 32'(a_id_ready), 0);
    check("lu_b_hazard", 32'(b_hazard), 0);
    check("lu_b_ready", 32'(b_id_ready), 1);
    tick();
    at_neg();
    check("lu_bubble", 32'(a_valid), 0);
    check("lu_hazard_drop", 32'(a_hazard), 0);
    check("lu_cnt", 32'(a_cnt), 1);
    check("lu_b_valid", 32'(b_valid), 1);
    check("lu_b_rd", 32'(b_rd), 3);
    tick();
    instr_valid = 1'b0;
    at_neg();
    check("lu_add_valid", 32'(a_valid), 1);
    check("lu_add_rd", 32'(a_rd), 3);
    check("lu_add_op_b", 32'(a_op_b), 32'(OP_B_REG));
    check("lu_cnt_hold", 32'(a_cnt), 1);
    tick();

    // backpressure holding addi x1,x0,-1
    do_reset();
    instr = 32'hFFF00093; pc = 32'h200; instr_valid = 1'b1; ex_ready = 1'b0;
    tick();
    instr = 32'h00208113; pc = 32'h204;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      check($sformatf("bp_imm%0d", k), a_imm, 32'hFFFFFFFF);
      check($sformatf("bp_ready%0d", k), 32'(a_id_ready), 0);
      check($sformatf("bp_pc%0d", k), a_pc, 32'h200);
      tick();
    end
    ex_ready = 1'b1;
    at_neg();
    check("bp_release_ready", 32'(a_id_ready), 1);
    tick();
    instr_valid = 1'b0;
    at_neg();
    check("bp_next_valid", 32'(a_valid), 1);
    check("bp_next_imm", a_imm, 2);
    check("bp_next_rd", 32'(a_rd), 2);
    check("bp_next_pc", a_pc, 32'h204);
    check("bp_b_imm", b_imm, 2);
    tick();
    at_neg();
    check("bp_no_dup", 32'(a_valid), 0);
    tick();

    // M extension: mul x3,x1,x2 then mulhu x3,x1,x2
    do_reset();
    instr = 32'h022081B3; instr_valid = 1'b1;
    tick();
    instr = 32'h0220B1B3;
    at_neg();
    check("m_req", 32'(a_md_req), 1);
    check("m_op", 32'(a_md_op), 0);
    check("m_inv", 32'(a_inv), 0);
    check("m_rs2_used", 32'(a_rs2_used), 1);
    check("m_rd_used", 32'(a_rd_used), 1);
    check("m_b_inv", 32'(b_inv), 1);
    check("m_b_req", 32'(b_md_req), 0);
    tick();
    instr_valid = 1'b0;
    at_neg();
    check("m_op_mulhu", 32'(a_md_op), 3);
    tick();

    // directed decode table, back to back
    do_reset();
    for (int i = 0; i < 10; i++) begin
      instr = vecs[i].instr; instr_valid = 1'b1;
      tick();
      at_neg();
      check($sformatf("dec%0d_imm", i), a_imm, vecs[i].imm);
      check($sformatf("dec%0d_alu", i), 32'(a_alu), 32'(vecs[i].alu));
      check($sformatf("dec%0d_inv", i), 32'(a_inv), 32'(vecs[i].inv));
      if (vecs[i].chk) begin
        check($sformatf("dec%0d_rd_used", i), 32'(a_rd_used), 32'(vecs[i].rd_used));
        check($sformatf("dec%0d_req", i), 32'(a_req), 32'(vecs[i].req));
        check($sformatf("dec%0d_we", i), 32'(a_we), 32'(vecs[i].we));
        check($sformatf("dec%0d_sext", i), 32'(a_sext), 32'(vecs[i].sext));
        check($sformatf("dec%0d_dtype", i), 32'(a_dtype), 32'(vecs[i].dtype));
      end
      if (i == 5) check("dec_lui_rs1", 32'(a_rs1), 0);
      if (i == 6) check("dec_jalr_ctrl", 32'(a_ctrl), 32'(CTRL_JALR));
      if (i == 7) check("dec_unk_rs1_used", 32'(a_rs1_used), 0);
      if (i == 9) check("dec_beq_ctrl", 32'(a_ctrl), 32'(CTRL_BRANCH));
    end
    instr_valid = 1'b0;
    tick();

    // flush during a stall
    do_reset();
    instr = 32'h0000A103; instr_valid = 1'b1;
    tick();
    instr = 32'h001101B3; ex_ready = 1'b0;
    at_neg();
    check("fl_hazard", 32'(a_hazard), 1);
    tick();
    flush = 1'b1;
    at_neg();
    check("fl_ready", 32'(a_id_ready), 0);
    check("fl_cnt_before", 32'(a_cnt), 1);
    tick();
    flush = 1'b0; instr_valid = 1'b0;
    at_neg();
    check("fl_valid", 32'(a_valid), 0);
    check("fl_cnt", 32'(a_cnt), 1);
    tick();
    at_neg();
    check("fl_dropped", 32'(a_valid), 0);
    tick();

    // saturation of the 2-bit counter over 5 stall cycles
    do_reset();
    instr = 32'h0000A103; instr_valid = 1'b1;
    tick();
    instr = 32'h001101B3; ex_ready = 1'b0;
    repeat (2) tick();
    at_neg();
    check("sat_cnt2", 32'(a_cnt), 2);
    repeat (3) tick();
    at_neg();
    check("sat_cnt5", 32'(a_cnt), 3);
    check("sat_hazard", 32'(a_hazard), 1);
    check("sat_b_cnt", 32'(b_cnt), 0);

    // asynchronous reset mid-stream
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(a_valid), 0);
    check("arst_cnt", 32'(a_cnt), 0);
    check("arst_alu", 32'(a_alu), 32'(ALU_ADD));
    check("arst_rs1_used", 32'(a_rs1_used), 0);
    check("arst_rs2_used", 32'(a_rs2_used), 0);
    check("arst_rd_used", 32'(a_rd_used), 0);
    check("arst_dtype", 32'(a_dtype), 2);
    check("arst_req", 32'(a_req), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered RV32I instruction decode stage with an optional RV32M extension.
- Sits between fetch and execute, with a valid/ready handshake on both sides.
- The decoded fields are held in a single ID/EX pipeline register.
- Adds load-use hazard detection with bubble insertion, a synchronous flush, and a saturating stall counter.

Parameters:
- DATA_WIDTH, 32: width of the immediate and PC paths.
- RV32M_EN, 0: 1 decodes MUL/DIV (R_TYPE, funct7 = 0000001); 0 flags them invalid.
- HAZARD_EN, 1: 1 enables load-use stall logic; 0 ties stall to 0.
- CNT_WIDTH, 16: width of the stall counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- instr_i  in  32  fetched instruction
- pc_i  in  DATA_WIDTH  PC of instr_i
- instr_valid_i  in  1  fetch offers an instruction
- id_ready_o  out  1  stage accepts instr_i this cycle
- flush_i  in  1  kill the registered and the incoming instruction
- ex_ready_i  in  1  execute consumes the registered instruction
- valid_o  out  1  register holds a valid decoded instruction
- pc_o  out  DATA_WIDTH  PC of the registered instruction
- alu_operator_o  out  alu_opcode_e  ALU operation
- alu_op_a_mux_sel_o / alu_op_b_mux_sel_o  out  2 each  operand selects (package encodings)
- imm_o  out  DATA_WIDTH  extended immediate
- imm_valid_o  out  1  immediate present
- rs1_o, rs2_o, rd_o  out  5 each  register indices
- rs1_used_o, rs2_used_o, rd_used_o  out  1 each  register usage
- rf_wp_mux_sel_o, alu_result_mux_sel_o, ctrl_transfer_instr_o  out  2 each  package encodings
- data_req_o, data_we_o, data_sign_ext_o  out  1 each  LSU controls
- data_type_o  out  2  00 byte, 01 half, 10 word
- mul_div_req_o  out  1  M-extension operation
- mul_div_op_o  out  3  funct3 of the M operation
- instr_invalid_o  out  1  illegal instruction
- hazard_stall_o  out  1  load-use stall active this cycle (combinational)
- stall_cnt_o  out  CNT_WIDTH  saturating count of stall cycles

Behaviour:
- Reset (async, rst_n = 0):
  - valid_o = 0; all decoded outputs = 0; alu_operator_o = ALU_ADD; data_type_o = 10; stall_cnt_o = 0.
- Decode: combinational, from instr_i, per RV32I.
  - LUI forces rs1_o = 0 with OP_A_REG.
  - JALR imm = sign-extended instr[31:20].
  - Loads: data_sign_ext_o = ~instr[14]; imm is always sign-extended; funct3 011, 110 and 111 are invalid.
  - Stores: funct3 > 010 is invalid.
  - Unknown opcode: instr_invalid_o = 1 and all used flags = 0.
  - Invalid instructions are still registered with valid_o = 1 so that a downstream trap can fire.
- M extension:
  - RV32M_EN = 1 and R_TYPE with funct7 = 0000001: mul_div_req_o = 1, mul_div_op_o = funct3, rd_used_o = 1, rs1_used_o = rs2_used_o = 1.
  - RV32M_EN = 0: same encoding gives instr_invalid_o = 1 and mul_div_req_o = 0.
  - Any other R_TYPE funct7 besides 0000000/0100000 is invalid.
- Latency: 1 cycle from acceptance to valid_o.
- Handshake:
  - Acceptance = instr_valid_i & id_ready_o.
  - id_ready_o = (~valid_o | ex_ready_i) & ~hazard_stall_o & ~flush_i.
  - While valid_o & ~ex_ready_i, every registered output is held stable.
  - On valid_o & ex_ready_i with no acceptance: valid_o <= 0.
- Hazard condition:
  - hazard_stall_o = HAZARD_EN & instr_valid_i & valid_o & data_req_o & ~data_we_o & (rd_o != 0) & ((rs1_used & rs1 == rd_o) | (rs2_used & rs2 == rd_o)).
  - rs1/rs2 and their used flags in this expression come from the incoming decode.
- Hazard response:
  - Stall with ex_ready_i: load moves on, bubble inserted (valid_o <= 0), instruction not accepted.
  - Next cycle: valid_o = 0, so the stall drops and the instruction is accepted.
  - Stall without ex_ready_i: plain hold.
- Flush: highest priority. valid_o <= 0 next cycle; the incoming instruction is dropped; the stall counter does not increment.
- stall_cnt_o: increments on every cycle with hazard_stall_o = 1 and ~flush_i; saturates at all-ones with no wrap.
- No combinational path from ex_ready_i to any registered output.
- Combinational paths from ex_ready_i and flush_i to id_ready_o are permitted.
- unique case must never be violated: every case has a default.

Test Plan:
- Reset: assert rst_n = 0 mid-stream -> valid_o = 0, stall_cnt_o = 0, alu_operator_o = ALU_ADD, all used flags 0, immediately (async).
- Single accept: 0x00500093 (addi x1,x0,5) with valid, ex_ready = 1 -> next cycle valid_o = 1, ALU_ADD, imm_o = 5, rd_o = 1, rs1_used_o = 1, OP_B_IMM.
- Load-use:
  - Stimulus: 0x0000A103 (lw x2,0(x1)) then 0x001101B3 (add x3,x2,x1), ex_ready = 1.
  - Required: hazard_stall_o = 1 for exactly one cycle; one bubble (valid_o = 0); add appears the cycle after; stall_cnt_o = 1.
  - With HAZARD_EN = 0: no bubble.
- Backpressure: ex_ready = 0 for 3 cycles holding 0xFFF00093 (addi x1,x0,-1) -> imm_o = 0xFFFFFFFF stable, id_ready_o = 0; release -> next instruction follows with no loss or duplication.
- M extension: 0x022081B3 (mul x3,x1,x2) -> RV32M_EN = 1: mul_div_req_o = 1, mul_div_op_o = 000, instr_invalid_o = 0; RV32M_EN = 0: instr_invalid_o = 1, mul_div_req_o = 0.
- Flush and saturation:
  - flush_i during a stall -> valid_o = 0 next cycle, counter unchanged, incoming instruction dropped.
  - CNT_WIDTH = 2 with 5 stall cycles -> stall_cnt_o = 3.
